// File: rtl/pipelined_csa_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready handshakes.
// Each stage adds one S-bit slice; upper operand slices ride along until their carry arrives.
module pipelined_csa_adder #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned BLK         = 4,
  parameter int unsigned BLK_PER_STG = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned S       = BLK * BLK_PER_STG;
  localparam int unsigned NUM_STG = WIDTH / S;
  localparam int unsigned LAST    = NUM_STG - 1;

  // Block 0 ripples; later blocks precompute both carry-in cases and select.
  function automatic logic [S:0] slice_add(input logic [S-1:0] x, input logic [S-1:0] y,
                                           input logic ci);
    logic [S-1:0] s;
    logic         c;
    logic [BLK:0] r0;
    logic [BLK:0] r1;
    s  = '0;
    c  = ci;
    r0 = '0;
    r1 = '0;
    for (int unsigned j = 0; j < BLK_PER_STG; j++) begin
      if (j == 0) begin
        for (int unsigned i = 0; i < BLK; i++) begin
          s[i] = x[i] ^ y[i] ^ c;
          c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
      end else begin
        r0 = {1'b0, x[j*BLK +: BLK]} + {1'b0, y[j*BLK +: BLK]};
        r1 = r0 + {{BLK{1'b0}}, 1'b1};
        s[j*BLK +: BLK] = c ? r1[BLK-1:0] : r0[BLK-1:0];
        c = c ? r1[BLK] : r0[BLK];
      end
    end
    return {c, s};
  endfunction

  logic advance;

  for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
    localparam int unsigned RW = WIDTH - k * S;  // operand bits still to be added
    localparam int unsigned LW = (k + 1) * S;    // result bits produced so far

    logic          valid_q, valid_d;
    logic          carry_q, carry_d;
    logic [LW-1:0] sum_q, sum_d;
    logic          src_c;
    logic [RW-1:0] src_a, src_b;
    logic [S:0]    res;

    if (k == 0) begin : g_src
      always_comb begin
        valid_d = in_valid;
        src_a   = a;
        src_b   = sub ? ~b : b;
        src_c   = sub | c_in;
      end
    end else begin : g_src
      always_comb begin
        valid_d = g_stg[k-1].valid_q;
        src_a   = g_stg[k-1].g_fwd.op_a_q;
        src_b   = g_stg[k-1].g_fwd.op_b_q;
        src_c   = g_stg[k-1].carry_q;
      end
    end

    always_comb begin
      res     = slice_add(src_a[S-1:0], src_b[S-1:0], src_c);
      carry_d = res[S];
    end

    if (k == 0) begin : g_sum
      always_comb sum_d = res[S-1:0];
    end else begin : g_sum
      always_comb sum_d = {res[S-1:0], g_stg[k-1].sum_q};
    end

    // Bubbles keep their old data so idle stages do not toggle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (advance) begin
        valid_q <= valid_d;
        if (valid_d) begin
          carry_q <= carry_d;
          sum_q   <= sum_d;
        end
      end
    end

    if (k < LAST) begin : g_fwd
      logic [RW-S-1:0] op_a_q, op_a_d;
      logic [RW-S-1:0] op_b_q, op_b_d;

      always_comb begin
        op_a_d = src_a[RW-1:S];
        op_b_d = src_b[RW-1:S];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          op_a_q <= '0;
          op_b_q <= '0;
        end else if (advance && valid_d) begin
          op_a_q <= op_a_d;
          op_b_q <= op_b_d;
        end
      end
    end else begin : g_tail
      logic ovf_q, ovf_d;
      logic zero_q, zero_d;

      always_comb begin
        ovf_d  = (src_a[RW-1] == src_b[RW-1]) && (sum_d[LW-1] != src_a[RW-1]);
        zero_d = (sum_d == '0);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (advance && valid_d) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
  end

  always_comb begin
    advance   = !g_stg[LAST].valid_q || out_ready;
    in_ready  = advance;
    out_valid = g_stg[LAST].valid_q;
    sum       = g_stg[LAST].sum_q;
    c_out     = g_stg[LAST].carry_q;
    ovf       = g_stg[LAST].g_tail.ovf_q;
    zero      = g_stg[LAST].g_tail.zero_q;
  end

endmodule

// File: tb/tb_pipelined_csa_adder.sv
// Self-checking bench for pipelined_csa_adder: directed corner cases, backpressure,
// mid-flight reset and random streams on three parameterisations.
module tb_pipelined_csa_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] a, b;
  logic        c_in, sub;
  logic [2:0]  in_valid, in_ready, out_valid, out_ready, c_out, ovf, zero;
  logic [31:0] sum0;
  logic [15:0] sum1;
  logic [63:0] sum2;

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  pipelined_csa_adder u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[31:0]), .b(b[31:0]), .c_in(c_in), .sub(sub), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .sum(sum0), .c_out(c_out[0]), .ovf(ovf[0]), .zero(zero[0])
  );

  pipelined_csa_adder #(.WIDTH(16), .BLK(4), .BLK_PER_STG(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[15:0]), .b(b[15:0]), .c_in(c_in), .sub(sub), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .sum(sum1), .c_out(c_out[1]), .ovf(ovf[1]), .zero(zero[1])
  );

  pipelined_csa_adder #(.WIDTH(64), .BLK(8), .BLK_PER_STG(4)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .sum(sum2), .c_out(c_out[2]), .ovf(ovf[2]), .zero(zero[2])
  );

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ov;
    logic        z;
    int          acc;
  } exp_t;

  function automatic int wd(int d);
    case (d)
      0:       return 32;
      1:       return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int nstg(int d);
    return (d == 2) ? 2 : 4;
  endfunction

  function automatic logic [63:0] mask(int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] get_sum(int d);
    case (d)
      0:       return {32'd0, sum0};
      1:       return {48'd0, sum1};
      default: return sum2;
    endcase
  endfunction

  // Reference: plain wide arithmetic on the operand values.
  function automatic exp_t model(int w, logic [63:0] av, logic [63:0] bv, logic ci, logic sb,
                                 int acc);
    exp_t        e;
    logic [64:0] t;
    logic [63:0] aa, bb;
    aa    = av & mask(w);
    bb    = (sb ? ~bv : bv) & mask(w);
    t     = {1'b0, aa} + {1'b0, bb} + {64'd0, (sb ? 1'b1 : ci)};
    e.s   = t[63:0] & mask(w);
    e.co  = t[w];
    e.z   = (e.s == 64'd0);
    e.ov  = (aa[w-1] == bb[w-1]) && (e.s[w-1] != aa[w-1]);
    e.acc = acc;
    return e;
  endfunction

  function automatic logic [63:0] rnd_op(int w);
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       r = 64'hFFFF_FFFF_FFFF_FFFF;
      1:       r = 64'd0;
      2:       r = 64'd1 << (w - 1);
      default: ;
    endcase
    return r & mask(w);
  endfunction

  // Drives one op into DUT d on an idle pipe and returns its result and latency.
  task automatic send_one(input int d, input logic [63:0] av, input logic [63:0] bv,
                          input logic ci, input logic sb, output logic [63:0] s,
                          output logic co, output logic ov, output logic z, output int lat);
    int m;
    @(negedge clk);
    a = av; b = bv; c_in = ci; sub = sb;
    in_valid[d] = 1'b1;
    out_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    a = '0; b = '0;
    m = 1;
    while (!out_valid[d] && m < 20) begin
      @(negedge clk);
      m++;
    end
    s = get_sum(d); co = c_out[d]; ov = ovf[d]; z = zero[d];
    lat = out_valid[d] ? m : -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = '0; out_ready = '0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if ({out_valid[d], c_out[d], ovf[d], zero[d]} !== 4'b0 || get_sum(d) !== 64'd0) begin
        n_errors++;
        $display("FAIL reset_outputs dut%0d: got v=%b sum=%h c=%b o=%b z=%b, want all 0",
                 d, out_valid[d], get_sum(d), c_out[d], ovf[d], zero[d]);
      end
    end
    n_checks++;
    if (in_ready !== 3'b111) begin
      n_errors++;
      $display("FAIL reset_in_ready: got %b, want 111", in_ready);
    end
    rst_n = 1'b1;
    out_ready = 3'b111;
  endtask

  task automatic test_carry_chain();
    logic [63:0] s; logic co, ov, z; int lat;
    send_one(0, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, s, co, ov, z, lat);
    n_checks++;
    if ({s[31:0], co, ov, z} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL carry_chain: got sum=%h c=%b o=%b z=%b, want 00000000 1 0 1", s, co, ov, z);
    end
    n_checks++;
    if (lat !== 4) begin
      n_errors++;
      $display("FAIL carry_chain_latency: got %0d, want 4", lat);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] s; logic co, ov, z; int lat;
    send_one(0, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, s, co, ov, z, lat);
    n_checks++;
    if ({s[31:0], co, ov, z} !== {32'h8000_0000, 1'b0, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL ovf_add: got sum=%h c=%b o=%b z=%b, want 80000000 0 1 0", s, co, ov, z);
    end
    send_one(0, 64'h8000_0000, 64'h1, 1'b0, 1'b1, s, co, ov, z, lat);
    n_checks++;
    if ({s[31:0], co, ov, z} !== {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL ovf_sub: got sum=%h c=%b o=%b z=%b, want 7fffffff 1 1 0", s, co, ov, z);
    end
  endtask

  task automatic test_sub_borrow();
    logic [63:0] s; logic co, ov, z; int lat;
    send_one(0, 64'd5, 64'd7, 1'b1, 1'b1, s, co, ov, z, lat);
    n_checks++;
    if ({s[31:0], co, ov, z} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL sub_borrow: got sum=%h c=%b o=%b z=%b, want fffffffe 0 0 0", s, co, ov, z);
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = rnd_op(32); b = rnd_op(32); c_in = 1'($urandom); sub = 1'($urandom);
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    a = '0; b = '0;
    @(negedge clk);
    n_checks++;
    if (out_valid[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL midflight_first_result: got out_valid=%b, want 1", out_valid[0]);
    end
    out_ready[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid[0], c_out[0], ovf[0], zero[0], in_ready[0]} !== 5'b00001 || sum0 !== 32'd0) begin
      n_errors++;
      $display("FAIL midflight_async_reset: got v=%b sum=%h c=%b o=%b z=%b rdy=%b, want 0 0 0 0 0 1",
               out_valid[0], sum0, c_out[0], ovf[0], zero[0], in_ready[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid[0], c_out[0], ovf[0], zero[0]} !== 4'b0 || sum0 !== 32'd0) begin
        n_errors++;
        $display("FAIL midflight_idle cycle %0d: got v=%b sum=%h c=%b o=%b z=%b, want all 0",
                 i, out_valid[0], sum0, c_out[0], ovf[0], zero[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t        q[$];
    exp_t        e;
    int          sent = 0, got = 0, cyc = 0;
    logic        stall_prev = 1'b0, acc;
    logic [31:0] h_sum = '0;
    logic [2:0]  h_flags = '0;
    @(negedge clk);
    a = rnd_op(32); b = rnd_op(32); c_in = 1'($urandom); sub = 1'($urandom);
    in_valid[0] = 1'b1;
    while (got < 8 && cyc < 200) begin
      if (stall_prev) begin
        n_checks++;
        if (out_valid[0] !== 1'b1 || sum0 !== h_sum || {c_out[0], ovf[0], zero[0]} !== h_flags) begin
          n_errors++;
          $display("FAIL bp_hold cycle %0d: got v=%b sum=%h flags=%b, want 1 %h %b",
                   cyc, out_valid[0], sum0, {c_out[0], ovf[0], zero[0]}, h_sum, h_flags);
        end
      end
      out_ready[0] = (cyc % 4 == 0) || (cyc % 4 == 3);
      #1;
      if (out_valid[0]) begin
        n_checks++;
        if (in_ready[0] !== out_ready[0]) begin
          n_errors++;
          $display("FAIL bp_in_ready cycle %0d: got %b, want %b", cyc, in_ready[0], out_ready[0]);
        end
      end
      if (out_valid[0] && out_ready[0]) begin
        n_checks++;
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL bp_extra_result: got sum=%h, want no result", sum0);
        end else begin
          e = q.pop_front();
          if ({32'd0, sum0} !== e.s || {c_out[0], ovf[0], zero[0]} !== {e.co, e.ov, e.z}) begin
            n_errors++;
            $display("FAIL bp_result %0d: got sum=%h flags=%b, want %h %b",
                     got, sum0, {c_out[0], ovf[0], zero[0]}, e.s[31:0], {e.co, e.ov, e.z});
          end
        end
        got++;
      end
      stall_prev = out_valid[0] && !out_ready[0];
      h_sum = sum0;
      h_flags = {c_out[0], ovf[0], zero[0]};
      acc = in_valid[0] && in_ready[0];
      if (acc) begin
        q.push_back(model(32, a, b, c_in, sub, 0));
        sent++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (sent < 8) begin
          a = rnd_op(32); b = rnd_op(32); c_in = 1'($urandom); sub = 1'($urandom);
        end else begin
          in_valid[0] = 1'b0;
          a = '0; b = '0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (got != 8 || q.size() != 0) begin
      n_errors++;
      $display("FAIL bp_count: got %0d results (%0d pending), want 8 (0 pending)", got, q.size());
    end
    out_ready[0] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      n_checks++;
      if (out_valid[0] !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_duplicate: got out_valid=%b after drain, want 0", out_valid[0]);
      end
    end
  endtask

  task automatic test_sweep(input int d, input int n);
    exp_t q[$];
    exp_t e;
    int   sent = 0, got = 0, cyc = 0, lat, w;
    int   bad = 0;
    logic acc;
    w = wd(d);
    @(negedge clk);
    out_ready[d] = 1'b1;
    a = rnd_op(w); b = rnd_op(w); c_in = 1'($urandom); sub = 1'($urandom);
    in_valid[d] = 1'b1;
    while (got < n && cyc < n + 50) begin
      #1;
      if (out_valid[d]) begin
        n_checks++;
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL sweep%0d_extra_result: got sum=%h, want no result", w, get_sum(d));
        end else begin
          e = q.pop_front();
          lat = edge_cnt - e.acc + 1;
          if (get_sum(d) !== e.s || {c_out[d], ovf[d], zero[d]} !== {e.co, e.ov, e.z} ||
              lat != nstg(d)) begin
            n_errors++;
            bad++;
            if (bad <= 5)
              $display("FAIL sweep%0d_result %0d: got sum=%h flags=%b lat=%0d, want %h %b %0d",
                       w, got, get_sum(d), {c_out[d], ovf[d], zero[d]}, lat, e.s,
                       {e.co, e.ov, e.z}, nstg(d));
          end
        end
        got++;
      end
      acc = in_valid[d] && in_ready[d];
      if (acc) begin
        q.push_back(model(w, a, b, c_in, sub, edge_cnt + 1));
        sent++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (sent < n) begin
          a = rnd_op(w); b = rnd_op(w); c_in = 1'($urandom); sub = 1'($urandom);
        end else begin
          in_valid[d] = 1'b0;
          a = '0; b = '0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (got != n || q.size() != 0) begin
      n_errors++;
      $display("FAIL sweep%0d_count: got %0d results (%0d pending), want %0d", w, got, q.size(), n);
    end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_overflow();
    test_sub_borrow();
    test_reset_midflight();
    test_backpressure();
    test_sweep(0, 300);
    test_sweep(1, 1000);
    test_sweep(2, 1000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/pipelined_csa_adder.md
# pipelined_csa_adder

Parametrised, pipelined carry-select adder/subtractor with valid/ready handshakes on input and output. It generalises the team's fixed 16-bit carry-select adder in three ways: arbitrary width, configurable block and stage size, and a subtract mode. The datapath is split into register-separated stages so the adder can close timing at wider widths. It sits between operand-producing logic and the ALU result path, and sustains one operation per cycle.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of BLK*BLK_PER_STG.
- BLK, 4: bits per carry-select block. Block 0 of each stage is ripple-carry; the other blocks compute sums for carry-in 0 and 1 and select between them.
- BLK_PER_STG, 2: blocks per pipeline stage. NUM_STG = WIDTH/(BLK*BLK_PER_STG); the default gives 4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block accepts operands this cycle.
- a, b  in  WIDTH each  operands.
- c_in  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+c_in; 1: a-b (a + ~b + 1).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- ovf  out  1  signed overflow: (a'[MSB]==b'[MSB]) && (sum[MSB]!=a'[MSB]), where b' is b after inversion.
- zero  out  1  sum==0.

## Operation
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Stage k (0..NUM_STG-1) computes bits [k*S +: S], where S = BLK*BLK_PER_STG.
  - It uses the carry registered by stage k-1; stage 0 uses the effective carry-in.
  - The effective carry-in is c_in when sub=0 and 1 when sub=1.
- Operand skew:
  - Upper slices of a and b' travel through delay registers alongside the partial sum, so stage k sees its slice exactly when its carry arrives.
  - Lower result bits are delayed so all bits leave together.
- Each stage register holds: valid bit, partial sum, carry, and the pending operand slices. The final stage also holds the MSB operand signs for ovf.
- Flow control (global stall):
  - advance = !out_valid || out_ready.
  - When advance=1, every stage register loads from its predecessor, and stage 0 loads {in_valid, inputs}.
  - When advance=0, all stage registers hold.
  - in_ready = advance, combinational from out_ready and out_valid.
- Bubbles are not collapsed. A stage whose valid bit is 0 carries don't-care data, but its valid bit is still 0.
- sum, c_out, ovf and zero are registered in the final stage. zero and ovf are computed before that register, so there is no extra latency.
- Outputs are held stable while out_valid && !out_ready.
- The operation is fully defined for all inputs; no X propagation from valid data.

## Timing
- Latency: an input accepted on edge N presents out_valid=1 after edge N+NUM_STG-1, i.e. NUM_STG cycles from acceptance to result visibility. With defaults, 4.
- Throughput: 1 result/cycle while out_ready=1.
- Stall: out_ready low with out_valid high freezes the entire pipe, and in_ready drops in the same cycle. When out_ready rises, in_ready rises in the same cycle.
- Simultaneous events: an output transfer and an input transfer in one cycle are both legal and lose nothing.
- Reset:
  - Asynchronous assertion clears every stage valid bit immediately, so out_valid=0, sum=0, c_out=0, ovf=0 and zero=0.
  - in_ready=1 throughout reset.
  - Data registers also reset to 0.
  - Reset during a stall or mid-flight discards all in-flight operations; no partial results emerge.
- Deassertion is taken synchronously to clk by the surrounding reset synchroniser. The first input transfer is legal on the first edge after rst_n rises.
- Wrap-around: carries beyond the MSB appear only on c_out; sum wraps modulo 2^WIDTH.

## Test plan
- Reset mid-flight: issue 3 back-to-back ops, assert rst_n=0 asynchronously mid-cycle, release, then idle 6 cycles. Required: out_valid=0 immediately and for all 6 cycles, with outputs all zero.
- Carry chain, defaults: a=0xFFFFFFFF, b=0x00000001, c_in=0, sub=0. Required after 4 cycles: sum=0x00000000, c_out=1, zero=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, sub=0. Required: sum=0x80000000, c_out=0, ovf=1.
  - Also a=0x80000000, b=0x00000001, sub=1. Required: sum=0x7FFFFFFF, c_out=1, ovf=1.
- Subtract with borrow: a=5, b=7, sub=1, c_in=1 (c_in must be ignored). Required: sum=0xFFFFFFFE, c_out=0, ovf=0, zero=0.
- Backpressure:
  - Stream 8 random ops with out_ready toggling in a 1-0-0-1 pattern. Required: results are in order, match a reference model, and none are dropped or duplicated. in_ready equals out_ready whenever out_valid=1.
  - The hold rule must be checked on each stalled cycle.
- Parameter sweep: WIDTH=16/BLK=4/BLK_PER_STG=1 (4 stages) and WIDTH=64/BLK=8/BLK_PER_STG=4 (2 stages). Run 1000 random ops each at full throughput. Required: exact match, and latency equals NUM_STG.
